bht_predictor: RTL and testbench

- Parametrised branch history table: one saturating counter per entry, indexed by fetch PC.
- Supplies the registered d_guess_taken consumed by decode's next-PC mux, aligned with the instruction entering decode.
- Decode ANDs the prediction with isbranch.
- Trained by the resolved branch outcome (pcsrc) from decode.
- Successor to the fixed not-taken guess.
- Adds depth/counter-width generalisation and a self-initialising table.

---
 rtl/bht_predictor_pkg.sv | 18 +
 rtl/bht_predictor_sat.sv | 22 ++
 rtl/bht_predictor.sv | 122 ++++++++++++
 tb/tb_bht_predictor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bht_predictor_pkg.sv
// Shared BHT types: FSM states, pipeline index width and the update bundle
// carried from decode back to the predictor.
package bht_predictor_pkg;

  localparam int BHT_IDX_W = 8;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } bht_state_e;

  typedef struct packed {
    logic                 valid;
    logic [BHT_IDX_W-1:0] idx;
    logic                 taken;
  } bht_upd_t;

endpackage

// File: rtl/bht_predictor_sat.sv
// Saturating up/down counter next-value logic.
// Never wraps: clamps at 0 and at all-ones.
module bht_predictor_sat #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             inc_i,
  output logic [CTR_W-1:0] ctr_o
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != CTR_MAX) ctr_o = ctr_i + CTR_W'(1);
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table with self-initialising sweep and registered guess.
// Define BHT_GSHARE_EN to XOR a global history register into the index.
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int ENTRIES  = 256,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1,
`ifdef BHT_GSHARE_EN
  parameter int GHR_W    = 8,
`endif
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      f_pc,
  input  logic             f_req,
  input  logic             f_stall,
  input  logic             d_flush,
  output logic             d_guess_taken,
  output logic [IDX_W-1:0] d_pred_idx,
  output logic             ready,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  bht_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CTR_W-1:0] tbl_q [ENTRIES];
  logic [CTR_W-1:0] tbl_d [ENTRIES];
  logic             guess_q, guess_d;
  logic [IDX_W-1:0] pidx_q, pidx_d;
  logic [IDX_W-1:0] lidx;
  logic [CTR_W-1:0] upd_ctr;
  logic             pred;
  logic             unused_pc;

`ifdef BHT_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  assign lidx = f_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);

  always_comb begin
    ghr_d = ghr_q;
    if (state_q == ST_RUN && upd_valid)
      ghr_d = GHR_W'({ghr_q, upd_taken});
  end

  always_ff @(posedge clk) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end
`else
  assign lidx = f_pc[IDX_W+1:2];
`endif

  assign unused_pc = ^{f_pc[31:IDX_W+2], f_pc[1:0]};

  bht_predictor_sat #(.CTR_W(CTR_W)) u_sat (
    .ctr_i (tbl_q[upd_idx]),
    .inc_i (upd_taken),
    .ctr_o (upd_ctr)
  );

  // Reads use tbl_q, so a same-cycle update is not visible to the lookup.
  assign pred = (state_q == ST_RUN) & tbl_q[lidx][CTR_W-1];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tbl_d   = tbl_q;
    if (state_q == ST_INIT) begin
      tbl_d[ptr_q] = CTR_W'(INIT_CTR);
      ptr_d        = ptr_q + IDX_W'(1);
      if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = ST_RUN;
    end else if (upd_valid) begin
      tbl_d[upd_idx] = upd_ctr;
    end
  end

  always_comb begin
    guess_d = guess_q;
    pidx_d  = pidx_q;
    if (d_flush) begin
      guess_d = 1'b0;
      pidx_d  = '0;
    end else if (f_stall) begin
      guess_d = guess_q;
      pidx_d  = pidx_q;
    end else if (f_req) begin
      guess_d = pred;
      pidx_d  = lidx;
    end else begin
      guess_d = 1'b0;
      pidx_d  = lidx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
      guess_q <= 1'b0;
      pidx_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      guess_q <= guess_d;
      pidx_q  <= pidx_d;
    end
  end

  always_ff @(posedge clk) begin
    tbl_q <= tbl_d;
  end

  assign d_guess_taken = guess_q;
  assign d_pred_idx    = pidx_q;
  assign ready         = (state_q == ST_RUN);

endmodule

// File: tb/tb_bht_predictor.sv
// Scoreboard bench for bht_predictor (ENTRIES=16, CTR_W=2, INIT_CTR=1).
// Define BHT_GSHARE_EN to exercise the history-indexed build instead.
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] f_pc = '0;
  logic        f_req = 1'b0;
  logic        f_stall = 1'b0;
  logic        d_flush = 1'b0;
  logic        d_guess_taken;
  logic [3:0]  d_pred_idx;
  logic        ready;
  logic        upd_valid = 1'b0;
  logic [3:0]  upd_idx = '0;
  logic        upd_taken = 1'b0;

  bht_predictor #(
    .ENTRIES  (16),
    .CTR_W    (2),
`ifdef BHT_GSHARE_EN
    .GHR_W    (2),
`endif
    .INIT_CTR (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .f_pc          (f_pc),
    .f_req         (f_req),
    .f_stall       (f_stall),
    .d_flush       (d_flush),
    .d_guess_taken (d_guess_taken),
    .d_pred_idx    (d_pred_idx),
    .ready         (ready),
    .upd_valid     (upd_valid),
    .upd_idx       (upd_idx),
    .upd_taken     (upd_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         id;
    bit         cg;
    bit         g;
    bit         ci;
    logic [3:0] i;
    bit         cr;
    bit         r;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle, compare the outputs against entries due now.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_%0d: due cyc %0d seen at %0d", e.id, e.cyc, cyc);
      end else begin
        if (e.cg) begin
          checks++;
          if (d_guess_taken !== e.g) begin
            errors++;
            $display("FAIL guess_%0d cyc %0d: got %b want %b",
                     e.id, cyc, d_guess_taken, e.g);
          end
        end
        if (e.ci) begin
          checks++;
          if (d_pred_idx !== e.i) begin
            errors++;
            $display("FAIL idx_%0d cyc %0d: got %0d want %0d",
                     e.id, cyc, d_pred_idx, e.i);
          end
        end
        if (e.cr) begin
          checks++;
          if (ready !== e.r) begin
            errors++;
            $display("FAIL ready_%0d cyc %0d: got %b want %b",
                     e.id, cyc, ready, e.r);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int at, input bit cg, input bit g,
                      input bit ci, input logic [3:0] i,
                      input bit cr, input bit r);
    exp_t x;
    x.cyc = at; x.id = next_id; x.cg = cg; x.g = g;
    x.ci = ci; x.i = i; x.cr = cr; x.r = r;
    next_id++;
    sb.push_back(x);
  endtask

  task automatic slot(input logic [31:0] pc, input logic req,
                      input logic stall, input logic flush,
                      input logic uv, input logic [3:0] ui,
                      input logic ut, input bit chk,
                      input bit eg, input logic [3:0] ei);
    f_pc = pc; f_req = req; f_stall = stall; d_flush = flush;
    upd_valid = uv; upd_idx = ui; upd_taken = ut;
    if (chk) push(cyc + 1, 1'b1, eg, 1'b1, ei, 1'b0, 1'b0);
    tick();
  endtask

  task automatic lookup(input logic [31:0] pc, input bit eg,
                        input logic [3:0] ei);
    slot(pc, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, eg, ei);
  endtask

  task automatic upd(input logic [3:0] idx, input logic t);
    slot(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, idx, t, 1'b0, 1'b0, 4'd0);
  endtask

  // Release rst now; ready must rise on the 16th edge after this point.
  task automatic sweep(input bit init_upd);
    int c0;
    rst = 1'b0;
    c0 = cyc;
    for (int k = 1; k <= 16; k++)
      push(c0 + k, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, (k == 16));
    for (int i = 0; i < 16; i++) begin
      f_pc = 32'(i * 4); f_req = 1'b1;
      f_stall = 1'b0; d_flush = 1'b0;
      upd_valid = init_upd; upd_idx = 4'(15 - i); upd_taken = 1'b0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    f_req = 1'b1;
    f_pc = 32'h14;
    tick();
    push(cyc, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    tick();
    sweep(1'b1);

`ifdef BHT_GSHARE_EN
    upd(4'd0, 1'b1);
    upd(4'd0, 1'b1);
    lookup(32'h14, 1'b0, 4'd6);
    lookup(32'h18, 1'b0, 4'd5);
`else
    // All counters must still be 1: one taken step makes every guess 1.
    for (int i = 0; i < 16; i++) upd(4'(i), 1'b1);
    for (int i = 0; i < 16; i++) lookup(32'(i * 4), 1'b1, 4'(i));
    for (int i = 0; i < 16; i++) upd(4'(i), 1'b0);

    slot(32'h24, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd9);

    lookup(32'h14, 1'b0, 4'd5);
    upd(4'd5, 1'b1);
    lookup(32'h14, 1'b1, 4'd5);
    upd(4'd5, 1'b1);
    lookup(32'h14, 1'b1, 4'd5);
    repeat (3) upd(4'd5, 1'b1);
    lookup(32'h14, 1'b1, 4'd5);
    upd(4'd5, 1'b0);
    lookup(32'h14, 1'b1, 4'd5);
    upd(4'd5, 1'b0);
    lookup(32'h14, 1'b0, 4'd5);
    repeat (3) upd(4'd5, 1'b0);
    lookup(32'h14, 1'b0, 4'd5);
    upd(4'd5, 1'b1);
    lookup(32'h14, 1'b0, 4'd5);
    upd(4'd5, 1'b1);
    lookup(32'h14, 1'b1, 4'd5);

    slot(32'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 4'd7);
    lookup(32'h1C, 1'b1, 4'd7);

    slot(32'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd7);
    slot(32'h04, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd7);
    slot(32'h08, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd7);
    slot(32'h10, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);

    upd(4'd3, 1'b1);
    upd(4'd3, 1'b1);
    lookup(32'h0C, 1'b1, 4'd3);
    rst = 1'b1;
    f_req = 1'b1; f_pc = 32'h0C; upd_valid = 1'b0;
    push(cyc + 1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    tick();
    sweep(1'b0);
    lookup(32'h0C, 1'b0, 4'd3);
`endif

    f_req = 1'b0; upd_valid = 1'b0; f_stall = 1'b0; d_flush = 1'b0;
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
